// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: locked round-robin arbiter with a registered one-hot grant.
// The grant is held until the owner pulses done_i. On release the pointer moves
// just past the owner, so the last winner drops to lowest priority, and
// re-arbitration happens on that same edge.
// Optional feature: define RR_ONEHOT_ARBITER_TIMEOUT_EN to revoke a grant after
// TIMEOUT_CYC cycles without done_i. timeout_o pulses for one cycle on revocation.
module rr_onehot_arbiter #(
    parameter int N           = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    input  logic         done_i,
    output logic [N-1:0] grant_o,
    output logic         busy_o,
    output logic         timeout_o
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    // Elaboration-time sanity check on the configuration.
    if (N < 2 || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("rr_onehot_arbiter: N and TIMEOUT_CYC must both be >= 2");
    end

    state_t             state_q, state_d;
    logic [N-1:0]       grant_q, grant_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   ptr_rel;
    logic [PTR_W-1:0]   arb_ptr;
    logic [N-1:0]       hi_mask, hi_req, pick, win_oh;
    logic               tmo_hit;
    logic               release_now;
    logic               new_grant;

    // Index of the current owner. The grant is one-hot, so a plain scan is enough.
    always_comb begin
        owner = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) owner = PTR_W'(i);
        end
    end

    // Pointer after a release: one past the owner, wrapping explicitly so that
    // non-power-of-two N never reaches ptr == N.
    assign ptr_rel     = (owner == PTR_W'(N-1)) ? '0 : owner + PTR_W'(1);
    assign release_now = (state_q == GRANT) && (done_i || tmo_hit);
    assign arb_ptr     = release_now ? ptr_rel : ptr_q;

    // Per-requester mask of positions at or above the pointer.
    for (genvar i = 0; i < N; i++) begin : g_mask
        localparam logic [PTR_W-1:0] IDX = PTR_W'(i);
        assign hi_mask[i] = (IDX >= arb_ptr);
    end

    // Round-robin pick: lowest request at/above the pointer, else lowest overall
    // (the wrapped part of the scan). pick & -pick isolates its lowest set bit.
    always_comb begin
        hi_req = req_i & hi_mask;
        pick   = (hi_req != '0) ? hi_req : req_i;
        win_oh = pick & (~pick + N'(1));
    end

    // Next-state logic: issue, hold, release/re-arbitrate, or drop back to idle.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        new_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i != '0) begin
                    grant_d   = win_oh;
                    state_d   = GRANT;
                    new_grant = 1'b1;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d = ptr_rel;
                    if (req_i != '0) begin
                        grant_d   = win_oh;
                        new_grant = 1'b1;
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State, grant and pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef RR_ONEHOT_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q;

    // A plain done_i wins over the timeout, so no pulse in that case.
    assign tmo_hit = (state_q == GRANT) && !done_i &&
                     (cnt_q == CNT_W'(TIMEOUT_CYC-1));

    // Hold counter: counts grant cycles, restarts on every fresh grant and in idle.
    always_comb begin
        cnt_d = '0;
        if (state_d == GRANT && !new_grant) cnt_d = cnt_q + CNT_W'(1);
    end

    // Counter and one-cycle revocation pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_hit;
        end
    end

    assign timeout_o = tmo_q;
`else
    assign tmo_hit   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign grant_o = grant_q;
    assign busy_o  = (state_q == GRANT);

endmodule
